// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared VGA timing defaults, pixel types and the RGB332 expander.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int c_coord_w = 11;

    // 640x480@60 defaults
    localparam int c_def_h_active = 640;
    localparam int c_def_h_fp     = 16;
    localparam int c_def_h_sync   = 96;
    localparam int c_def_h_bp     = 48;
    localparam int c_def_v_active = 480;
    localparam int c_def_v_fp     = 10;
    localparam int c_def_v_sync   = 2;
    localparam int c_def_v_bp     = 33;

    typedef logic [c_coord_w-1:0] coord_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } scan_flags_t;

    localparam scan_flags_t c_flags_idle = '0;

    function automatic int scan_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    localparam int c_def_h_total = scan_total(c_def_h_active, c_def_h_fp, c_def_h_sync, c_def_h_bp);
    localparam int c_def_v_total = scan_total(c_def_v_active, c_def_v_fp, c_def_v_sync, c_def_v_bp);

    // Bit replication so that full-scale codes map to 8'hFF and zero to 8'h00
    function automatic rgb888_t expand_rgb332(input rgb332_t p);
        rgb888_t o;
        o.r = {p.r, p.r, p.r[2:1]};
        o.g = {p.g, p.g, p.g[2:1]};
        o.b = {p.b, p.b, p.b, p.b};
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_flag_delay.sv
`default_nettype none
// ============================================================================
// Module   : vga_flag_delay
// Purpose  : DEPTH-stage shift register aligning scan flags with returned pixels.
// Revision : 1.0 - initial release
// ============================================================================
module vga_flag_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  scan_flags_t i_flags,
    output scan_flags_t o_flags
);

    scan_flags_t r_stage [DEPTH];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= c_flags_idle;
            end
        end else begin
            r_stage[0] <= i_flags;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_flags = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_ctrl
// Purpose  : Raster counters, sync/blank generation and pixel output stage.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE    = c_def_h_active,
    parameter int   H_FP        = c_def_h_fp,
    parameter int   H_SYNC      = c_def_h_sync,
    parameter int   H_BP        = c_def_h_bp,
    parameter int   V_ACTIVE    = c_def_v_active,
    parameter int   V_FP        = c_def_v_fp,
    parameter int   V_SYNC      = c_def_v_sync,
    parameter int   V_BP        = c_def_v_bp,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   PIPE_LAT    = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [10:0] oCoord_X,
    output logic [10:0] oCoord_Y,
    input  logic [7:0]  iRGB,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        frameDone
);

    localparam int c_h_total = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t c_h_max      = coord_t'(c_h_total - 1);
    localparam coord_t c_v_max      = coord_t'(c_v_total - 1);
    localparam coord_t c_h_act      = coord_t'(H_ACTIVE);
    localparam coord_t c_v_act      = coord_t'(V_ACTIVE);
    localparam coord_t c_hs_start   = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t c_hs_end     = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t c_vs_start   = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t c_vs_end     = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t      r_h_cnt;
    coord_t      r_v_cnt;
    logic        w_h_wrap;
    logic        w_v_wrap;
    scan_flags_t w_flags;
    scan_flags_t w_flags_d;
    rgb888_t     w_rgb_exp;
    rgb888_t     r_rgb;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;
    logic        r_frame_done;

    assign w_h_wrap = (r_h_cnt == c_h_max);
    assign w_v_wrap = (r_v_cnt == c_v_max);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign oCoord_X = r_h_cnt;
    assign oCoord_Y = r_v_cnt;

    always_comb begin
        w_flags        = c_flags_idle;
        w_flags.active = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
        w_flags.hs     = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
        w_flags.vs     = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);
    end

    // Flags travel alongside the drawer/mux pipeline so they meet iRGB for the same pixel
    vga_flag_delay #(
        .DEPTH   (PIPE_LAT)
    ) u_flag_delay (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_flags (w_flags),
        .o_flags (w_flags_d)
    );

    assign w_rgb_exp = expand_rgb332(rgb332_t'(iRGB));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rgb        <= '0;
            r_hs         <= ~SYNC_ACTIVE;
            r_vs         <= ~SYNC_ACTIVE;
            r_blank_n    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_rgb        <= w_flags_d.active ? w_rgb_exp : '0;
            r_hs         <= w_flags_d.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vs         <= w_flags_d.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_blank_n    <= w_flags_d.active;
            // Taken straight from the counters: game logic wants it early, not pin-aligned
            r_frame_done <= (r_h_cnt == '0) && (r_v_cnt == c_v_act);
        end
    end

    assign VGA_R       = r_rgb.r;
    assign VGA_G       = r_rgb.g;
    assign VGA_B       = r_rgb.b;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign frameDone   = r_frame_done;

endmodule
`default_nettype wire

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
Raster scan initiator for the VGA path. Generates the pixel coordinates (oCoord_X/oCoord_Y) that every object drawer and the object mux consume. Captures the composited 8-bit RRRGGGBB pixel that comes back after a fixed pipeline latency, expands it to 24-bit RGB, and drives HS/VS/BLANK_N aligned to that pixel. Also emits a once-per-frame pulse that game logic uses to update object positions.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of HS/VS (0 = active-low)
PIPE_LAT, 1, CLK cycles from oCoord valid to iRGB valid (drawer + mux registers), range 1..4

Ports:
CLK  in  1  pixel clock (25.175 MHz nominal), all logic on rising edge
RESET  in  1  synchronous, active-high reset
oCoord_X  out  11  current horizontal count (0..H_TOTAL-1)
oCoord_Y  out  11  current vertical count (0..V_TOTAL-1)
iRGB  in  8  composited pixel RRRGGGBB for coordinates issued PIPE_LAT cycles earlier
VGA_R  out  8  red
VGA_G  out  8  green
VGA_B  out  8  blue
VGA_HS  out  1  horizontal sync
VGA_VS  out  1  vertical sync
VGA_BLANK_N  out  1  1 = active video on pins
frameDone  out  1  single-cycle pulse, first cycle of vertical blanking

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must fit 11 bits.
- hCnt increments every CLK and wraps H_TOTAL-1 -> 0. vCnt increments only on the hCnt wrap and wraps V_TOTAL-1 -> 0 when both counters are at their maximum.
- oCoord_X/oCoord_Y are the counter registers driven directly, with no combinational logic. They keep counting through blanking; downstream drawers must tolerate out-of-screen values.
- Stage-0 flags are computed from the counters:
  - active = hCnt<H_ACTIVE && vCnt<V_ACTIVE
  - hs = hCnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs = vCnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), so VS spans whole lines, with edges at hCnt=0.
- The flags pass through a delay line of PIPE_LAT registers, so they are aligned with iRGB.
- Output register stage, one cycle:
  - VGA_R/G/B = active_d ? expand(iRGB) : 0
  - VGA_HS = hs_d ? SYNC_ACTIVE : ~SYNC_ACTIVE; VGA_VS likewise
  - VGA_BLANK_N = active_d
- Total latency from coordinate to pins is PIPE_LAT+1 cycles, and is identical for RGB, HS, VS and BLANK_N.
- expand() bit mapping: R = {r2,r1,r0,r2,r1,r0,r2,r1}; G = same pattern on g; B = {b1,b0,b1,b0,b1,b0,b1,b0}. Results: 3'b111 -> 8'hFF, 0 -> 0.
- frameDone: registered, high for exactly one cycle. It goes high in the cycle after the counters read (hCnt=0, vCnt=V_ACTIVE), and is not delayed by PIPE_LAT.
- Reset (any cycle, including mid-line or mid-sync):
  - next cycle: hCnt=vCnt=0, delay line cleared to inactive
  - VGA_R/G/B=0, VGA_BLANK_N=0
  - VGA_HS/VGA_VS=~SYNC_ACTIVE
  - frameDone=0
  - scanning restarts from (0,0) in the first cycle after RESET deasserts.
- RESET held high: counters hold 0, outputs hold their reset values.
- iRGB is ignored (does not reach the pins) whenever the aligned active flag is 0.

Decomposition:
- Shared package vga_pkg holds:
  - default timing constants (640x480@60 values above)
  - the H_TOTAL/V_TOTAL derivation
  - the rgb332 type
  - the expand_rgb332 function, which the object mux also reuses for debug
- One sub-module, vga_flag_delay: a parameterised-depth shift register for {active,hs,vs}, with synchronous reset to the inactive values.
- Counters and the output stage stay in the top module.

Test Plan:
- Line timing: run 2 lines after reset -> oCoord_X sequence is 0..799 with wrap; oCoord_Y steps 0 -> 1 exactly when X wraps; VGA_HS low for exactly 96 cycles, starting 656+PIPE_LAT+1 cycles after (0,0).
- Frame timing: run 420000 cycles -> VGA_VS low for exactly 1600 cycles per frame; frameDone high exactly once per frame, at cycle 480*800+1 after the frame start.
- Pixel alignment (PIPE_LAT=1): drive iRGB=8'hE0 only when a registered copy of the coordinates equals (0,0), and 8'h00 otherwise -> 2 cycles after oCoord=(0,0): R=FF, G=00, B=00, BLANK_N=1. Repeat with iRGB=8'h03 -> B=FF.
- Blanking: hold iRGB=8'hFF -> RGB=0 and BLANK_N=0 for all pins cycles mapping to X>=640 or Y>=480, and RGB=FFFFFF in the active area.
- Reset mid-sync: assert RESET for 1 cycle while HS is low at (700,100) -> next cycle HS/VS high, RGB=0, BLANK_N=0; oCoord=(0,0) in the first cycle after release; full timing is correct thereafter.
- PIPE_LAT=3 build: repeat the pixel alignment scenario -> the pixel appears 4 cycles after its coordinate, and the HS edges shift by the same amount.
